// File: rtl/ma_cvxif_pkg.sv
// Purpose: shared types for the CV-X-IF matrix-accelerator issue front-end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ma_cvxif_pkg;

    localparam int unsigned MA_XLEN = 32;
    localparam int unsigned MA_ID_W = 3;

    // Major opcode claimed by the coprocessor (custom-3).
    localparam logic [6:0] CUSTOM3_OPCODE = 7'h7B;

    typedef enum logic [2:0] {
        OP_MLD  = 3'd0,
        OP_MST  = 3'd1,
        OP_MMUL = 3'd2,
        OP_MADD = 3'd3,
        OP_MCFG = 3'd4
    } ma_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RES  = 2'd3
    } ma_disp_state_e;

    typedef struct packed {
        logic               vld;
        logic [MA_ID_W-1:0] id;
        ma_op_e             op;
        logic [MA_XLEN-1:0] rs1;
        logic [MA_XLEN-1:0] rs2;
        logic [4:0]         rd;
        logic               we;
        logic               committed;
        logic               killed;
    } ma_cvxif_entry_t;

endpackage

// File: rtl/ma_cvxif_decoder.sv
// Purpose: decode a custom-3 instruction word into legal/op/rd/writeback.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_instr[14:0] (low bits of the instruction word) -> o_legal, o_op, o_rd, o_writeback.
module ma_cvxif_decoder
    import ma_cvxif_pkg::*;
#(
    parameter logic [6:0] CustomOpcode = CUSTOM3_OPCODE
) (
    input  logic [14:0] i_instr,
    output logic        o_legal,
    output logic [2:0]  o_op,
    output logic [4:0]  o_rd,
    output logic        o_writeback
);

    logic [2:0] w_funct3;

    always_comb begin
        w_funct3    = i_instr[14:12];
        o_op        = w_funct3;
        o_rd        = i_instr[11:7];
        // funct3 encodings 000..100 are the five defined ops.
        o_legal     = (i_instr[6:0] == CustomOpcode) && (w_funct3 <= 3'd4);
        o_writeback = o_legal && (w_funct3 == OP_MCFG) && (o_rd != 5'd0);
    end

endmodule

// File: rtl/ma_cvxif_issue_queue.sv
// Purpose: CV-X-IF front-end: decode/accept, in-order queue with commit/kill CAM, single-outstanding dispatch.
// Latency: commit of idle head -> acc_req_valid_o next cycle; acc response -> result_valid_o next cycle.
// Backpressure: issue stalls when queue full or operands invalid; req/rsp/result use valid-ready handshakes.
// Ports: issue_* (core issue), commit_* (commit/kill), acc_req_*/acc_rsp_* (accelerator), result_* (to core).
module ma_cvxif_issue_queue
    import ma_cvxif_pkg::*;
#(
    parameter int unsigned XLEN         = MA_XLEN,
    parameter int unsigned IdWidth      = MA_ID_W,
    parameter int unsigned Depth        = 4,
    parameter logic [6:0]  CustomOpcode = CUSTOM3_OPCODE
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [31:0]        issue_instr_i,
    input  logic [IdWidth-1:0] issue_id_i,
    input  logic [XLEN-1:0]    issue_rs1_i,
    input  logic [XLEN-1:0]    issue_rs2_i,
    input  logic [1:0]         issue_rs_valid_i,
    output logic               issue_accept_o,
    output logic               issue_writeback_o,
    input  logic               commit_valid_i,
    input  logic [IdWidth-1:0] commit_id_i,
    input  logic               commit_kill_i,
    output logic               acc_req_valid_o,
    input  logic               acc_req_ready_i,
    output logic [2:0]         acc_op_o,
    output logic [XLEN-1:0]    acc_rs1_o,
    output logic [XLEN-1:0]    acc_rs2_o,
    input  logic               acc_rsp_valid_i,
    output logic               acc_rsp_ready_o,
    input  logic [XLEN-1:0]    acc_rsp_data_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [IdWidth-1:0] result_id_o,
    output logic [XLEN-1:0]    result_data_o,
    output logic [4:0]         result_rd_o,
    output logic               result_we_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic            w_legal, w_wb;
    logic [2:0]      w_op;
    logic [4:0]      w_rd;
    logic            w_full, w_push, w_pop;
    logic            w_head_commit, w_head_kill;
    logic [Depth-1:0] w_match;
    logic            w_unused_instr;
    ma_cvxif_entry_t w_head;
    ma_disp_state_e  r_state, w_state_nxt;

    ma_cvxif_entry_t   r_q [Depth];
    logic [PtrW-1:0]   r_head, r_tail;
    logic [PtrW:0]     r_count;

    ma_op_e            r_acc_op;
    logic [XLEN-1:0]   r_acc_rs1, r_acc_rs2, r_res_data;
    logic [IdWidth-1:0] r_res_id;
    logic [4:0]        r_res_rd;
    logic              r_res_we;

    ma_cvxif_decoder #(.CustomOpcode(CustomOpcode)) u_decoder (
        .i_instr     (issue_instr_i[14:0]),
        .o_legal     (w_legal),
        .o_op        (w_op),
        .o_rd        (w_rd),
        .o_writeback (w_wb)
    );

    assign w_unused_instr = ^issue_instr_i[31:15];

    // Issue handshake: illegal words are answered (rejected) immediately;
    // legal ones wait for space and both operands. No bypass of a same-cycle pop.
    assign w_full            = (r_count == (PtrW+1)'(Depth));
    assign issue_ready_o     = !w_legal || (!w_full && (&issue_rs_valid_i));
    assign issue_accept_o    = w_legal && issue_ready_o && issue_valid_i;
    assign issue_writeback_o = w_wb;
    assign w_push            = issue_accept_o;

    always_comb begin
        w_match = '0;
        for (int i = 0; i < Depth; i++) begin
            w_match[i] = commit_valid_i && r_q[i].vld && (r_q[i].id == commit_id_i);
        end
    end

    // Head decision folds in a commit/kill arriving this cycle so an idle
    // dispatcher can issue the request on the very next cycle.
    assign w_head        = r_q[r_head];
    assign w_head_commit = w_head.vld && !w_head.killed &&
                           (w_head.committed || (w_match[r_head] && !commit_kill_i));
    assign w_head_kill   = w_head.vld && !w_head.committed &&
                           (w_head.killed || (w_match[r_head] && commit_kill_i));
    assign w_pop         = (r_state == ST_IDLE) && (w_head_commit || w_head_kill);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) r_q[i] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (w_match[i]) begin
                    if (commit_kill_i) r_q[i].killed    <= 1'b1;
                    else               r_q[i].committed <= 1'b1;
                end
            end
            // Pushes only land on an invalid tail slot, so they never collide
            // with a CAM update or with the popped head entry.
            if (w_push) begin
                r_q[r_tail] <= '{vld: 1'b1, id: issue_id_i, op: ma_op_e'(w_op),
                                 rs1: issue_rs1_i, rs2: issue_rs2_i, rd: w_rd,
                                 we: w_wb, committed: 1'b0, killed: 1'b0};
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_q[r_head].vld <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Dispatch FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Dispatch FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_head_commit)   w_state_nxt = ST_REQ;
            ST_REQ:  if (acc_req_ready_i) w_state_nxt = ST_WAIT;
            ST_WAIT: if (acc_rsp_valid_i) w_state_nxt = ST_RES;
            ST_RES:  if (result_ready_i)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Dispatch FSM: outputs
    always_comb begin
        acc_req_valid_o = (r_state == ST_REQ);
        acc_rsp_ready_o = (r_state == ST_WAIT);
        result_valid_o  = (r_state == ST_RES);
    end

    // Request and result fields are captured once and held for the whole handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc_op   <= OP_MLD;
            r_acc_rs1  <= '0;
            r_acc_rs2  <= '0;
            r_res_id   <= '0;
            r_res_rd   <= '0;
            r_res_we   <= 1'b0;
            r_res_data <= '0;
        end else begin
            if (w_pop && w_head_commit) begin
                r_acc_op  <= w_head.op;
                r_acc_rs1 <= w_head.rs1;
                r_acc_rs2 <= w_head.rs2;
                r_res_id  <= w_head.id;
                r_res_rd  <= w_head.rd;
                r_res_we  <= w_head.we;
            end
            if ((r_state == ST_WAIT) && acc_rsp_valid_i) r_res_data <= acc_rsp_data_i;
        end
    end

    assign acc_op_o      = r_acc_op;
    assign acc_rs1_o     = r_acc_rs1;
    assign acc_rs2_o     = r_acc_rs2;
    assign result_id_o   = r_res_id;
    assign result_data_o = r_res_data;
    assign result_rd_o   = r_res_rd;
    assign result_we_o   = r_res_we;

    a_no_same_cycle_commit: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(commit_valid_i && issue_accept_o && (commit_id_i == issue_id_i)));
    a_unique_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(w_match));

endmodule

// File: doc/ma_cvxif_issue_queue.md
Name: ma_cvxif_issue_queue

Overview:
- CV-X-IF coprocessor front-end sitting directly downstream of the CVA6 core (CvxifEn=1, XLEN=32) and upstream of the matrix accelerator datapath.
- Decodes custom-3 instructions offered on the issue interface and accepts or rejects them in the same cycle.
- Buffers accepted instructions in order until the core commits or kills them.
- Dispatches committed instructions one at a time to the accelerator and returns results to the core tagged with the original instruction ID.

Parameters:
- XLEN, 32, operand/result width.
- IdWidth, 3, CV-X-IF instruction ID width (log2 of 8 scoreboard entries).
- Depth, 4, instruction queue entries; power of two, at least 2.
- CustomOpcode, 7'h7B, major opcode claimed by the block.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- issue_valid_i  in  1  core offers instruction
- issue_ready_o  out  1  issue handshake complete this cycle
- issue_instr_i  in  32  instruction word
- issue_id_i  in  IdWidth  instruction ID
- issue_rs1_i / issue_rs2_i  in  XLEN  source operands
- issue_rs_valid_i  in  2  operand valid bits
- issue_accept_o  out  1  instruction claimed by coprocessor
- issue_writeback_o  out  1  instruction will write rd
- commit_valid_i  in  1  commit/kill event
- commit_id_i  in  IdWidth  targeted ID
- commit_kill_i  in  1  1 = kill, 0 = commit
- acc_req_valid_o  out  1  request to accelerator
- acc_req_ready_i  in  1  accelerator ready
- acc_op_o  out  3  decoded op (ma_op_e)
- acc_rs1_o / acc_rs2_o  out  XLEN  operands
- acc_rsp_valid_i  in  1  accelerator response
- acc_rsp_ready_o  out  1  response accepted
- acc_rsp_data_i  in  XLEN  response data
- result_valid_o  out  1  result to core
- result_ready_i  in  1  core accepts result
- result_id_o  out  IdWidth  ID of result
- result_data_o  out  XLEN  result data
- result_rd_o  out  5  destination register
- result_we_o  out  1  write enable

Behaviour:
- Reset values:
  - All registered outputs are 0: acc_req_valid_o, result_valid_o, acc_rsp_ready_o, and all data/ID outputs.
  - Queue is empty; FSM is in IDLE.
  - issue_ready_o is combinational and reads 1 after reset.
- Decode (combinational):
  - Legal = instr[6:0]==CustomOpcode and funct3 in {000 MLD, 001 MST, 010 MMUL, 011 MADD, 100 MCFG}.
  - writeback = (op==MCFG) and rd!=0.
- Issue handshake:
  - issue_ready_o = !legal | (!full & &issue_rs_valid_i).
  - issue_accept_o = legal & issue_ready_o & issue_valid_i.
  - Illegal instructions are rejected in the same cycle (ready=1, accept=0).
  - Legal instructions stall (ready=0) while the queue is full or an operand is invalid.
  - On accept, the tail entry is written: {id, op, rs1, rs2, rd, we, committed=0, killed=0}; tail increments and wraps mod Depth.
- Commit:
  - commit_valid_i is CAM-matched against the IDs of valid entries.
  - A match sets committed (kill=0) or killed (kill=1).
  - No match: the event is ignored.
  - A commit for an ID issued in the same cycle never occurs (assertion).
  - Matching more than one valid entry is an error (assertion).
- Dispatch FSM:
  - IDLE:
    - Head valid & killed: pop, stay in IDLE (one cycle per killed entry).
    - Head valid & committed: load request registers, pop, go to REQ.
  - REQ: acc_req_valid_o=1 with stable fields; on acc_req_ready_i go to WAIT.
  - WAIT: acc_rsp_ready_o=1; on acc_rsp_valid_i capture data into the result registers and go to RES.
  - RES: result_valid_o=1, fields stable; on result_ready_i go to IDLE.
- Result rules:
  - Every committed instruction produces exactly one result; result_we_o equals the entry's writeback bit.
  - Killed instructions produce no result.
- Latency:
  - Commit-to-acc_req_valid_o is 1 cycle when the head is committed and the FSM is idle.
  - acc_rsp → result_valid_o is 1 cycle.
- Simultaneous events:
  - Issue accept and head pop in the same cycle are legal; count stays unchanged.
  - A full queue with a pop this cycle still reports issue_ready_o=0 (no bypass).
- Asynchronous reset mid-operation discards queue contents and any in-flight request or result immediately.

Decomposition:
- Shared package ma_cvxif_pkg holds:
  - ma_op_e (3-bit op enum)
  - the CUSTOM3 opcode constant
  - queue entry struct ma_cvxif_entry_t
  - dispatch FSM state enum
- Combinational sub-module ma_cvxif_decoder: instr → {legal, op, rd, writeback}.

Test Plan:
- MMUL (0x0000207B), ID 3, rs valid → accept=1, writeback=0; commit ID 3 → acc_op_o=MMUL next cycle; rsp 0xDEAD → result id 3, we=0, data 0xDEAD.
- Issue opcode 0x33 → ready=1, accept=0, queue unchanged.
- Issue IDs 0-3 with no commits → fifth legal issue sees ready=0; commit ID 0 and complete its result → ready returns to 1.
- Issue IDs 1, 2, 3; kill 2; commit 1 and 3 → accelerator sees only ops for IDs 1 and 3; results return in order 1, 3.
- MCFG with rd=x5, rs_valid=2'b01 → ready=0 until rs_valid=2'b11, then accept=1, writeback=1; result has rd=5, we=1.
- Assert rst_ni in WAIT with result pending → all outputs 0 asynchronously; after release, issue_ready_o=1 and the queue is empty.
